rotor_stepper: RTL and testbench
================================

// Module: rotor_stepper
// PURPOSE
//   Rotor position controller sitting directly upstream of the three rotor stages.
//   Accepts one letter per keypress and advances the rotor offsets before encipherment.
//   Rotor 1 always steps; rotors 2 and 3 step on notch carry.
//   Hands the letter plus the new rotate1/2/3 offsets to the combinational rotor chain,
//   with a one-cycle valid strobe.
// PARAMETERS
//   NOTCH1  5'd16  rotor-1 position (0..25) whose step carries into rotor 2
//   NOTCH2  5'd4   rotor-2 position (0..25) whose step carries into rotor 3
// PORTS
//   clk         in   1  system clock, all state on rising edge
//   reset       in   1  asynchronous, active-high reset
//   step_req    in   1  one-cycle request: letter_in is a new keypress
//   letter_in   in   5  letter code, 1..26 = A..Z; 0 and 27..31 invalid
//   load        in   1  one-cycle request: load initial rotor positions
//   init1/2/3   in   5  initial positions for rotors 1/2/3 (sampled on load)
//   busy        out  1  1 while a step is in flight (state != IDLE)
//   out_valid   out  1  one-cycle strobe: letter_out/rotate* are a new result
//   letter_out  out  5  captured letter_in, fed to rotor 1 input
//   rotate1/2/3 out  5  rotor positions 0..25, fed to rotor rotate inputs
//   bad_letter  out  1  one-cycle strobe: step_req rejected for invalid code
// BEHAVIOUR
//   Reset: state=IDLE; rotate1/2/3=0, letter_out=0, out_valid=0, bad_letter=0, busy=0.
//     Reset takes effect immediately, including mid-operation; no out_valid follows.
//   FSM states:
//     IDLE -> STEP : step_req=1 and letter_in in 1..26; letter_in captured.
//     STEP -> OUT  : rotor positions update (rules below).
//     OUT  -> IDLE : out_valid=1 for exactly this cycle.
//   Latency: step_req sampled at edge N; positions change at N+1; out_valid high N+1..N+2.
//   rotate* change only on the STEP edge and on load; they hold otherwise.
//   letter_out holds the last captured letter between requests.
//   step_req while busy=1: ignored (no queueing, no bad_letter).
//   step_req in IDLE with invalid code: bad_letter=1 next cycle; state stays IDLE;
//     positions unchanged.
//   load: honoured in any state. Each rotate_k <= init_k, or init_k-26 if init_k>25
//     (30 -> 4). Aborts any in-flight step: state=IDLE, no out_valid.
//     load wins over a simultaneous step_req, which is dropped.
//   Stepping rules (p1,p2,p3 = positions before step; all arithmetic mod 26, 25 -> 0):
//     c1 = (p1==NOTCH1)
//     rotor 1: p1+1 always
//     rotor 2: p2+1 if c1
//     rotor 3: p3+1 if c1 and p2==NOTCH2
//   Adders use 6-bit intermediates; stored positions are never 26..31.
// CONFIGURATION
//   ROTOR_DOUBLE_STEP_EN defined: historical double-step anomaly.
//     If p2==NOTCH2, rotor 2 and rotor 3 both step regardless of c1.
//     Rotor 2 also steps if c1. Rotor 2 advances at most +1 per keypress.
//   ROTOR_DOUBLE_STEP_EN undefined: pure odometer rules above.
// TESTING
//   1 reset; step_req letter 5 -> out_valid 2 cycles later.
//     letter_out=5; rotate=(1,0,0); busy high for 2 cycles.
//   2 load (16,0,0); step -> (17,1,0).
//     load (16,4,25); step -> (17,5,0): rotor 3 wraps 25->0.
//   3 load (0,4,0); step:
//     macro off -> (1,4,0)
//     macro on  -> (1,5,1); second step -> (2,5,1)
//   4 step_req letter 0 -> bad_letter pulse; no out_valid; positions unchanged.
//     step_req letter 27 -> same response.
//   5 step_req while busy=1 -> ignored; exactly one out_valid.
//     load and step_req in same cycle -> load applied, no out_valid.
//   6 reset asserted in STEP -> all outputs 0 immediately, no out_valid.
//     load init1=30 -> rotate1=4.

Source files
------------

// File: rtl/rotor_stepper.sv
// Rotor position controller: accepts one keypress, steps rotors odometer-style, strobes result.
// Optional ROTOR_DOUBLE_STEP_EN selects the historical double-step anomaly on rotor 2.
module rotor_stepper #(
    parameter logic [4:0] NOTCH1 = 5'd16,
    parameter logic [4:0] NOTCH2 = 5'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_req,
    input  logic [4:0] letter_in,
    input  logic       load,
    input  logic [4:0] init1,
    input  logic [4:0] init2,
    input  logic [4:0] init3,
    output logic       busy,
    output logic       out_valid,
    output logic [4:0] letter_out,
    output logic [4:0] rotate1,
    output logic [4:0] rotate2,
    output logic [4:0] rotate3,
    output logic       bad_letter
);

    typedef enum logic [1:0] {StIdle, StStep, StOut} state_e;

    state_e     state_q, state_d;
    logic [4:0] rot1_q, rot1_d, rot2_q, rot2_d, rot3_q, rot3_d;
    logic [4:0] letter_q, letter_d;
    logic       bad_q, bad_d;
    logic       c1, at_notch2, step2, step3, letter_ok;

    function automatic logic [4:0] inc26(input logic [4:0] p);
        logic [5:0] s;
        s = {1'b0, p} + 6'd1;
        return (s >= 6'd26) ? 5'd0 : s[4:0];
    endfunction

    // Codes 26..31 fold back into 0..5 via 5-bit wrap of the subtraction.
    function automatic logic [4:0] norm26(input logic [4:0] v);
        return (v > 5'd25) ? (v - 5'd26) : v;
    endfunction

    assign c1        = (rot1_q == NOTCH1);
    assign at_notch2 = (rot2_q == NOTCH2);
    assign letter_ok = (letter_in != 5'd0) && (letter_in <= 5'd26);

`ifdef ROTOR_DOUBLE_STEP_EN
    assign step2 = c1 | at_notch2;
    assign step3 = at_notch2;
`else
    assign step2 = c1;
    assign step3 = c1 & at_notch2;
`endif

    always_comb begin
        state_d  = state_q;
        rot1_d   = rot1_q;
        rot2_d   = rot2_q;
        rot3_d   = rot3_q;
        letter_d = letter_q;
        bad_d    = 1'b0;
        if (load) begin
            rot1_d  = norm26(init1);
            rot2_d  = norm26(init2);
            rot3_d  = norm26(init3);
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (step_req) begin
                        if (letter_ok) begin
                            letter_d = letter_in;
                            state_d  = StStep;
                        end else begin
                            bad_d = 1'b1;
                        end
                    end
                end
                StStep: begin
                    rot1_d  = inc26(rot1_q);
                    rot2_d  = step2 ? inc26(rot2_q) : rot2_q;
                    rot3_d  = step3 ? inc26(rot3_q) : rot3_q;
                    state_d = StOut;
                end
                StOut:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rot1_q   <= 5'd0;
            rot2_q   <= 5'd0;
            rot3_q   <= 5'd0;
            letter_q <= 5'd0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rot1_q   <= rot1_d;
            rot2_q   <= rot2_d;
            rot3_q   <= rot3_d;
            letter_q <= letter_d;
            bad_q    <= bad_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign out_valid  = (state_q == StOut);
    assign letter_out = letter_q;
    assign rotate1    = rot1_q;
    assign rotate2    = rot2_q;
    assign rotate3    = rot3_q;
    assign bad_letter = bad_q;

endmodule

// File: tb/tb_rotor_stepper.sv
// Bench for rotor_stepper: directed scenarios then random keypresses, checked against
// a cycle-level arithmetic model of the rotor positions.
module tb_rotor_stepper;

    logic       clk = 1'b0;
    logic       reset;
    logic       step_req;
    logic [4:0] letter_in;
    logic       load;
    logic [4:0] init1, init2, init3;
    logic       busy, out_valid, bad_letter;
    logic [4:0] letter_out, rotate1, rotate2, rotate3;

    localparam int N1 = 16;
    localparam int N2 = 4;

    int vectors     = 0;
    int miscompares = 0;

    // Model: positions, last letter, cycles since an accepted keypress (0 = idle).
    int m_r[3];
    int m_letter;
    int m_phase;
    bit m_bad;

    rotor_stepper dut (
        .clk       (clk),
        .reset     (reset),
        .step_req  (step_req),
        .letter_in (letter_in),
        .load      (load),
        .init1     (init1),
        .init2     (init2),
        .init3     (init3),
        .busy      (busy),
        .out_valid (out_valid),
        .letter_out(letter_out),
        .rotate1   (rotate1),
        .rotate2   (rotate2),
        .rotate3   (rotate3),
        .bad_letter(bad_letter)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_r[0] = 0; m_r[1] = 0; m_r[2] = 0;
        m_letter = 0; m_phase = 0; m_bad = 0;
    endtask

    task automatic model_advance();
        bit c1, n2, s2, s3;
        c1 = (m_r[0] == N1);
        n2 = (m_r[1] == N2);
`ifdef ROTOR_DOUBLE_STEP_EN
        s2 = c1 || n2;
        s3 = n2;
`else
        s2 = c1;
        s3 = c1 && n2;
`endif
        m_r[0] = (m_r[0] + 1) % 26;
        if (s2) m_r[1] = (m_r[1] + 1) % 26;
        if (s3) m_r[2] = (m_r[2] + 1) % 26;
    endtask

    task automatic model_edge(input bit s, input int l, input bit ld,
                              input int i1, input int i2, input int i3);
        bit nb = 0;
        if (ld) begin
            m_r[0] = i1 % 26; m_r[1] = i2 % 26; m_r[2] = i3 % 26;
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (s) begin
                if (l >= 1 && l <= 26) begin
                    m_letter = l;
                    m_phase  = 1;
                end else begin
                    nb = 1;
                end
            end
        end else if (m_phase == 1) begin
            model_advance();
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
        m_bad = nb;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"},   32'(busy),       32'(m_phase != 0));
        chk({tag, ".valid"},  32'(out_valid),  32'(m_phase == 2));
        chk({tag, ".letter"}, 32'(letter_out), m_letter);
        chk({tag, ".rot1"},   32'(rotate1),    m_r[0]);
        chk({tag, ".rot2"},   32'(rotate2),    m_r[1]);
        chk({tag, ".rot3"},   32'(rotate3),    m_r[2]);
        chk({tag, ".bad"},    32'(bad_letter), 32'(m_bad));
    endtask

    task automatic tick(input string tag, input bit s, input int l, input bit ld,
                        input int i1, input int i2, input int i3);
        @(negedge clk);
        step_req  = s;
        letter_in = 5'(l);
        load      = ld;
        init1     = 5'(i1);
        init2     = 5'(i2);
        init3     = 5'(i3);
        @(posedge clk);
        model_edge(s, l, ld, i1, i2, i3);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        tick(tag, 1'b0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic press(input string tag, input int l);
        tick(tag, 1'b1, l, 1'b0, 0, 0, 0);
        idle(tag);
        idle(tag);
    endtask

    task automatic load_pos(input string tag, input int i1, input int i2, input int i3);
        tick(tag, 1'b0, 0, 1'b1, i1, i2, i3);
    endtask

    // Asserted between edges so the check proves the reset is asynchronous.
    task automatic async_reset(input string tag);
        step_req = 1'b0; load = 1'b0; letter_in = 5'd0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; step_req = 1'b0; load = 1'b0; letter_in = 5'd0;
        init1 = 5'd0; init2 = 5'd0; init3 = 5'd0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Basic keypress latency and first step.
        tick("t1_acc", 1'b1, 5, 1'b0, 0, 0, 0);
        chk("t1_busy_acc", 32'(busy), 1);
        idle("t1_step");
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_rot1", 32'(rotate1), 1);
        chk("t1_letter", 32'(letter_out), 5);
        idle("t1_done");
        chk("t1_busy_end", 32'(busy), 0);

        // Notch carry into rotor 2, then rotor 3 wrap.
        load_pos("t2_load_a", 16, 0, 0);
        press("t2_step_a", 3);
        chk("t2_rot2_a", 32'(rotate2), 1);
        load_pos("t2_load_b", 16, 4, 25);
        press("t2_step_b", 4);
        chk("t2_rot1_b", 32'(rotate1), 17);
        chk("t2_rot2_b", 32'(rotate2), 5);
        chk("t2_rot3_b", 32'(rotate3), 0);

        // Rotor 2 sitting on its notch without a rotor-1 carry.
        load_pos("t3_load", 0, 4, 0);
        press("t3_step", 9);
`ifdef ROTOR_DOUBLE_STEP_EN
        chk("t3_rot2_ds", 32'(rotate2), 5);
        chk("t3_rot3_ds", 32'(rotate3), 1);
        press("t3_step2", 9);
        chk("t3_rot1_ds2", 32'(rotate1), 2);
        chk("t3_rot2_ds2", 32'(rotate2), 5);
`else
        chk("t3_rot2", 32'(rotate2), 4);
        chk("t3_rot3", 32'(rotate3), 0);
`endif

        // Invalid letters.
        tick("t4_bad0", 1'b1, 0, 1'b0, 0, 0, 0);
        chk("t4_bad0_pulse", 32'(bad_letter), 1);
        idle("t4_after0");
        tick("t4_bad27", 1'b1, 27, 1'b0, 0, 0, 0);
        chk("t4_bad27_pulse", 32'(bad_letter), 1);
        idle("t4_after27");

        // Requests while busy are dropped; load beats a simultaneous request.
        tick("t5_acc", 1'b1, 7, 1'b0, 0, 0, 0);
        tick("t5_busy1", 1'b1, 9, 1'b0, 0, 0, 0);
        tick("t5_busy2", 1'b1, 11, 1'b0, 0, 0, 0);
        chk("t5_letter", 32'(letter_out), 7);
        idle("t5_idle");
        tick("t5_ldstep", 1'b1, 3, 1'b1, 2, 2, 2);
        idle("t5_noval1");
        idle("t5_noval2");

        // Reset mid-step, then load normalisation.
        tick("t6_acc", 1'b1, 8, 1'b0, 0, 0, 0);
        async_reset("t6_reset");
        idle("t6_post1");
        idle("t6_post2");
        load_pos("t6_load30", 30, 27, 31);
        chk("t6_rot1", 32'(rotate1), 4);

        for (int i = 0; i < 400; i++) begin
            tick("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                 ($urandom_range(0, 19) == 0), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            if ($urandom_range(0, 59) == 0) async_reset("rand_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
